// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter.
// Optional clear input is enabled by defining COUNTER_CLEAR_EN.
package counter_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // MAX of 0 behaves like MAX of 1: the counter never leaves 0.
    function automatic cnt_t term_of(input cnt_t max);
        return (max == '0) ? '0 : max - cnt_t'(1);
    endfunction

endpackage

// File: rtl/counter_term_cmp.sv
// Terminal-value compare for max_counter: derives TERM from MAX and flags
// Count >= TERM (unsigned), so a lowered MAX still wraps on the next step.
module counter_term_cmp
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] count,
    output logic             at_term
);

    logic [WIDTH-1:0] term;

    generate
        if (WIDTH == CNT_W) begin : g_pkg_term
            assign term = term_of(max);
        end else begin : g_generic_term
            assign term = (max == '0) ? '0 : max - WIDTH'(1);
        end
    endgenerate

    assign at_term = (count >= term);

endmodule

// File: rtl/max_counter.sv
// Programmable modulo-N up-counter with a combinational terminal-count strobe
// for chaining; defining COUNTER_CLEAR_EN adds a synchronous clear input.
module max_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
`ifdef COUNTER_CLEAR_EN
    input  logic             clear,
`endif
    input  logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] Count,
    output logic             isMAX
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             at_term;
    logic             clear_int;

`ifdef COUNTER_CLEAR_EN
    assign clear_int = clear;
`else
    assign clear_int = 1'b0;
`endif

    counter_term_cmp #(
        .WIDTH(WIDTH)
    ) u_term_cmp (
        .max    (MAX),
        .count  (count_reg),
        .at_term(at_term)
    );

    always_comb begin
        count_next = count_reg;
        if (clear_int) begin
            count_next = '0;
        end else if (enable) begin
            count_next = at_term ? '0 : count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Unregistered so a downstream stage advances on the same edge we wrap.
    assign isMAX = rstn & enable & at_term & ~clear_int;
    assign Count = count_reg;

endmodule

// File: tb/tb_max_counter.sv
// Directed-vector bench for max_counter, plus a two-stage cascade sequence.
// Build with COUNTER_CLEAR_EN defined to also exercise the clear input.
module tb_max_counter;

    localparam int W = 8;

    typedef struct {
        logic         rstn;
        logic         en;
        logic         clr;
        logic [W-1:0] max;
        logic [W-1:0] exp_count;
        logic         exp_ismax;
    } vec_t;

    vec_t vecs[$];

    logic         clk = 1'b0;
    logic         rstn;
    logic         enable;
    logic         clear;
    logic [W-1:0] max;
    logic [W-1:0] count;
    logic         ismax;

    logic         rstn_c;
    logic         en_c;
    logic [W-1:0] count_a;
    logic [W-1:0] count_b;
    logic         ismax_a;
    logic         ismax_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    max_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .enable(enable),
`ifdef COUNTER_CLEAR_EN
        .clear (clear),
`endif
        .MAX   (max),
        .Count (count),
        .isMAX (ismax)
    );

    max_counter #(.WIDTH(W)) dut_a (
        .clk   (clk),
        .rstn  (rstn_c),
        .enable(en_c),
`ifdef COUNTER_CLEAR_EN
        .clear (1'b0),
`endif
        .MAX   (8'd10),
        .Count (count_a),
        .isMAX (ismax_a)
    );

    max_counter #(.WIDTH(W)) dut_b (
        .clk   (clk),
        .rstn  (rstn_c),
        .enable(ismax_a),
`ifdef COUNTER_CLEAR_EN
        .clear (1'b0),
`endif
        .MAX   (8'd9),
        .Count (count_b),
        .isMAX (ismax_b)
    );

    task automatic add(input logic r, input logic e, input logic c, input int m,
                       input int ec, input logic ei);
        vec_t v;
        v.rstn = r;
        v.en = e;
        v.clr = c;
        v.max = W'(m);
        v.exp_count = W'(ec);
        v.exp_ismax = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end else begin
            $display("ok   %s step %0d: %0d", name, idx, act);
        end
    endtask

    initial begin
        // Reset held with enable high.
        for (int i = 0; i < 10; i++) add(0, 1, 0, 10, 0, 0);
        // Free-running mod-10.
        for (int i = 0; i < 22; i++) add(1, 1, 0, 10, i % 10, (i % 10) == 9);
        add(1, 1, 0, 10, 2, 0);
        add(1, 1, 0, 10, 3, 0);
        add(1, 1, 0, 10, 4, 0);
        // Enable toggled 1,0,0,1 starting at Count=5.
        add(1, 1, 0, 10, 5, 0);
        add(1, 0, 0, 10, 6, 0);
        add(1, 0, 0, 10, 6, 0);
        add(1, 1, 0, 10, 6, 0);
        // MAX lowered to 4 while Count=7.
        add(1, 1, 0, 4, 7, 1);
        add(1, 1, 0, 4, 0, 0);
        add(1, 1, 0, 4, 1, 0);
        add(1, 1, 0, 4, 2, 0);
        add(1, 1, 0, 4, 3, 1);
        // MAX=0 and MAX=1.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 1);
        // Enable dropped while at terminal.
        add(1, 1, 0, 3, 0, 0);
        add(1, 1, 0, 3, 1, 0);
        add(1, 0, 0, 3, 2, 0);
        add(1, 0, 0, 3, 2, 0);
        add(1, 1, 0, 3, 2, 1);
        // MAX raised mid-count.
        add(1, 1, 0, 3, 0, 0);
        add(1, 1, 0, 3, 1, 0);
        add(1, 1, 0, 6, 2, 0);
        add(1, 1, 0, 6, 3, 0);
        add(1, 1, 0, 6, 4, 0);
        add(1, 1, 0, 6, 5, 1);
        // Reset mid-count, and reset while at terminal.
        add(1, 1, 0, 10, 0, 0);
        add(1, 1, 0, 10, 1, 0);
        add(0, 1, 0, 10, 2, 0);
        add(1, 1, 0, 10, 0, 0);
        add(0, 1, 0, 2, 1, 0);
        add(1, 0, 0, 2, 0, 0);
`ifdef COUNTER_CLEAR_EN
        for (int i = 0; i < 6; i++) add(1, 1, 0, 10, i, 0);
        add(1, 1, 1, 10, 6, 0);
        add(1, 0, 0, 10, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 10, 0, 0);
`endif

        rstn = 1'b0;
        enable = 1'b1;
        clear = 1'b0;
        max = 8'd10;
        rstn_c = 1'b0;
        en_c = 1'b0;
        @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstn = vecs[i].rstn;
            enable = vecs[i].en;
            clear = vecs[i].clr;
            max = vecs[i].max;
            #1;
            check("Count", i, int'(count), int'(vecs[i].exp_count));
            check("isMAX", i, int'(ismax), int'(vecs[i].exp_ismax));
        end

        // Cascade: mod-10 feeding mod-9, across a full 90-cycle period.
        @(negedge clk);
        rstn_c = 1'b0;
        en_c = 1'b1;
        @(negedge clk);
        rstn_c = 1'b1;
        for (int i = 0; i < 95; i++) begin
            int ea;
            int eb;
            ea = i % 10;
            eb = (i / 10) % 9;
            #1;
            check("cascade_A", i, int'(count_a), ea);
            check("cascade_B", i, int'(count_b), eb);
            check("cascade_A_isMAX", i, int'(ismax_a), int'(ea == 9));
            check("cascade_B_isMAX", i, int'(ismax_b), int'(ea == 9 && eb == 8));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
